result_frame_tx: RTL and testbench
==================================

# result_frame_tx

Downstream framing stage for the arithmetic/crypto result path. Consumes one 8-bit result plus its 4-bit operation code per handshake, from the registered output of the 16-to-1 result mux. Buffers results in a small FIFO and emits each as a 3-byte frame (header, data, checksum) over a valid/ready byte stream toward the output pins. Reports overflow when the producer pushes into a full buffer.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- in_valid  input  1  producer has a result.
- in_op  input  4  operation code of the result (mux select value 0..15).
- in_data  input  8  result byte.
- in_ready  output  1  high when the FIFO is not full. Driven from registered state only. Forced 0 while rst_n is low.
- out_valid  output  1  out_data holds a valid frame byte.
- out_data  output  8  frame byte.
- out_ready  input  1  consumer accepts the byte this cycle.
- frame_start  output  1  high while the header byte is presented.
- overflow  output  1  sticky; set when in_valid is high and in_ready is low.
- clr_ovf  input  1  clears overflow.
- level  output  clog2(DEPTH)+1  current FIFO occupancy, not counting the frame in flight.

## Operation
- Push: in_valid && in_ready writes {in_op, in_data} at the write pointer. Write pointer and level increment.
- Drop: in_valid && !in_ready sets overflow. The sample is discarded and FIFO state is unchanged.
- Overflow clear: clr_ovf clears overflow. If a drop occurs in the same cycle, the set wins.
- Pop: occurs only when the FSM loads a frame (see below). The entry is copied into hold registers hop/hdata; read pointer increments and level decrements.
- Simultaneous push and pop: both occur and level is unchanged. in_ready is still computed from the pre-cycle level, so a full FIFO rejects a push even in a popping cycle.
- Pointers: log2(DEPTH)-bit, wrap modulo DEPTH.
- Frame bytes:
  - HDR = {4'hA, hop}.
  - DAT = hdata.
  - CHK = ~((HDR + DAT) mod 256).
- FSM states: IDLE, HDR, DAT, CHK.
  - IDLE: out_valid=0. If level != 0: pop, go to HDR.
  - HDR: out_valid=1, out_data=HDR, frame_start=1. On out_ready go to DAT.
  - DAT: out_valid=1, out_data=DAT. On out_ready go to CHK.
  - CHK: out_valid=1, out_data=CHK. On out_ready: if level != 0, pop and go to HDR (back-to-back frames, no idle cycle); else go to IDLE.
- Stability: while out_valid && !out_ready, out_data and the state hold. The hold registers change only on a pop.
- Reset (any time, including mid-frame):
  - Pointers, level, state (IDLE), hold registers and overflow are all cleared.
  - The partial frame is abandoned and is not resumed.
  - Output values while/after reset: out_valid=0, out_data=0, frame_start=0, overflow=0, level=0, in_ready=0 (rising to 1 in the first cycle after rst_n returns high).

## Timing
- Latency from accepted push at cycle T, with IDLE and an empty FIFO:
  - level=1 at T+1; the pop happens in that cycle.
  - HDR is presented at T+2.
- Minimum frame duration: 3 cycles with out_ready held high.
- Sustained throughput: 1 result per 3 cycles. Back-to-back frames have zero gap.
- in_ready and level change only one cycle after the push or pop that causes them.
- out_valid has no combinational dependence on out_ready, in_valid or in_data.
- overflow rises the cycle after the rejected push.

## Test plan
- Single frame: push op=3, data=0x2C with out_ready=1 -> bytes 0xA3, 0x2C, 0x30 at T+2..T+4; frame_start only at T+2; then IDLE.
- Checksum wrap: push op=0xB, data=0xFF -> bytes 0xAB, 0xFF, 0x55.
- Fill and overflow (DEPTH=4): hold out_ready=0 and push 6 entries on consecutive cycles -> first 5 accepted (1 in hold, level=4), 6th rejected, in_ready=0, overflow=1. Then set out_ready=1 -> 15 consecutive valid bytes with correct order and checksums. Pulse clr_ovf -> overflow=0.
- Backpressure: toggle out_ready every other cycle during a frame -> each byte held stable until accepted; no byte duplicated or skipped.
- Simultaneous push/pop: at full level, push during the CHK->HDR transition -> push rejected (in_ready=0) and overflow set. At level 2, push during a pop -> accepted, level unchanged.
- Reset mid-frame: assert rst_n=0 while in DAT with 2 entries queued -> next cycle out_valid=0, level=0, overflow=0. After release, no bytes are emitted until a new push.

Source files
------------

// File: rtl/result_frame_tx.sv
// rtl/result_frame_tx.sv - buffered result framer emitting header/data/checksum byte frames
//
// Purpose: accepts {op, data} results from the result mux into a DEPTH-entry
// FIFO and sends each one as a 3-byte frame: {4'hA, op}, data, and
// ~(header + data). A sticky overflow flag records pushes made while full.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    producer handshake; in_ready is registered (not full)
//   in_op, in_data       operation code and result byte
//   out_valid/out_ready  consumer byte handshake
//   out_data             current frame byte (0 when idle)
//   frame_start          high while the header byte is presented
//   overflow, clr_ovf    sticky drop flag and its clear
//   level                FIFO occupancy, excluding the frame in flight

module result_frame_tx #(
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   input  logic [3:0]              in_op,
   input  logic [7:0]              in_data,
   output logic                    in_ready,
   output logic                    out_valid,
   output logic [7:0]              out_data,
   input  logic                    out_ready,
   output logic                    frame_start,
   output logic                    overflow,
   input  logic                    clr_ovf,
   output logic [$clog2(DEPTH):0]  level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_HDR,
      S_DAT,
      S_CHK
   } state_t;

   state_t          state_q, state_d;
   logic [11:0]     mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]   level_q, level_d;
   logic [3:0]      hop_q;
   logic [7:0]      hdata_q;
   logic            in_ready_q;
   logic            ovf_q, ovf_d;
   logic            push, drop, pop;
   logic [7:0]      hdr_byte;
   logic [7:0]      sum_byte;
   logic [7:0]      chk_byte;

   // in_ready_q already reflects the pre-cycle level, so a full FIFO
   // rejects a push even in a cycle that also pops.
   assign push = in_valid & in_ready_q;
   assign drop = in_valid & ~in_ready_q;

   assign hdr_byte = {4'hA, hop_q};
   assign sum_byte = hdr_byte + hdata_q;
   assign chk_byte = ~sum_byte;

   assign in_ready = in_ready_q;
   assign overflow = ovf_q;
   assign level    = level_q;

   always_comb begin
      state_d     = state_q;
      pop         = 1'b0;
      out_valid   = 1'b0;
      out_data    = 8'h00;
      frame_start = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (level_q != '0) begin
               pop     = 1'b1;
               state_d = S_HDR;
            end
         end
         S_HDR: begin
            out_valid   = 1'b1;
            out_data    = hdr_byte;
            frame_start = 1'b1;
            if (out_ready) state_d = S_DAT;
         end
         S_DAT: begin
            out_valid = 1'b1;
            out_data  = hdata_q;
            if (out_ready) state_d = S_CHK;
         end
         S_CHK: begin
            out_valid = 1'b1;
            out_data  = chk_byte;
            if (out_ready) begin
               // Load the next frame directly so back-to-back frames have no gap.
               if (level_q != '0) begin
                  pop     = 1'b1;
                  state_d = S_HDR;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      level_d = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   // A drop in the same cycle as a clear leaves the flag set.
   always_comb begin
      ovf_d = ovf_q;
      if (drop)         ovf_d = 1'b1;
      else if (clr_ovf) ovf_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         hop_q      <= '0;
         hdata_q    <= '0;
         in_ready_q <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         level_q    <= level_d;
         in_ready_q <= (level_d != FULL_LEVEL);
         ovf_q      <= ovf_d;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop) begin
            rd_ptr_q         <= rd_ptr_q + 1'b1;
            {hop_q, hdata_q} <= mem_q[rd_ptr_q];
         end
      end
   end

   // Storage is not reset; entries are only ever read behind the write pointer.
   always_ff @(posedge clk) begin
      if (rst_n && push) mem_q[wr_ptr_q] <= {in_op, in_data};
   end

endmodule

// File: tb/tb_result_frame_tx.sv
// tb/tb_result_frame_tx.sv - self-checking bench for result_frame_tx
module tb_result_frame_tx;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [3:0] in_op = 4'h0;
   logic [7:0] in_data = 8'h00;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_ready = 1'b0;
   logic       frame_start;
   logic       overflow;
   logic       clr_ovf = 1'b0;
   logic [2:0] level;

   int checks = 0;
   int failures = 0;

   result_frame_tx #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_op       (in_op),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_ready   (out_ready),
      .frame_start (frame_start),
      .overflow    (overflow),
      .clr_ovf     (clr_ovf),
      .level       (level)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a queue of buffered results, the frame in flight,
   // and the number of its bytes still to send.
   logic [11:0] m_q[$];
   logic [3:0]  m_hop = 4'h0;
   logic [7:0]  m_hdat = 8'h00;
   int          m_left = 0;
   bit          m_ovf = 1'b0;
   bit          m_rdy = 1'b0;
   bit          armed = 1'b0;
   logic [7:0]  log_b[$];
   logic [11:0] m_e;
   bit          m_push, m_pop;

   function automatic logic [7:0] m_byte();
      logic [7:0] h;
      logic [7:0] s;
      h = {4'hA, m_hop};
      s = h + m_hdat;
      if (m_left == 3) return h;
      if (m_left == 2) return m_hdat;
      return ~s;
   endfunction

   always @(negedge clk) begin
      if (armed) begin
         check("out_valid", out_valid, m_left != 0);
         check("frame_start", frame_start, m_left == 3);
         if (m_left != 0) check("out_data", out_data, m_byte());
         check("level", level, m_q.size());
         check("in_ready", in_ready, m_rdy);
         check("overflow", overflow, m_ovf);
         if (rst_n && out_valid && out_ready) log_b.push_back(out_data);
      end
      if (!rst_n) begin
         m_q.delete();
         m_hop  = 4'h0;
         m_hdat = 8'h00;
         m_left = 0;
         m_ovf  = 1'b0;
         m_rdy  = 1'b0;
      end else begin
         m_push = in_valid && m_rdy;
         if (m_left != 0 && out_ready) m_left--;
         m_pop = (m_left == 0) && (m_q.size() != 0);
         if (m_pop) begin
            m_e    = m_q.pop_front();
            m_hop  = m_e[11:8];
            m_hdat = m_e[7:0];
            m_left = 3;
         end
         if (m_push) m_q.push_back({in_op, in_data});
         if (in_valid && !m_rdy) m_ovf = 1'b1;
         else if (clr_ovf)       m_ovf = 1'b0;
         m_rdy = m_q.size() < DEPTH;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [3:0] op, input logic [7:0] data);
      in_valid = 1'b1;
      in_op    = op;
      in_data  = data;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic expect_frame(input string tag, input logic [7:0] h, input logic [7:0] d, input logic [7:0] c);
      tick();
      check({tag, "_hdr"}, out_data, h);
      check({tag, "_hdr_fs"}, frame_start, 1);
      tick();
      check({tag, "_dat"}, out_data, d);
      check({tag, "_dat_fs"}, frame_start, 0);
      tick();
      check({tag, "_chk"}, out_data, c);
      tick();
      check({tag, "_idle"}, out_valid, 0);
   endtask

   int n0;
   int cnt;

   initial begin
      // Reset state
      tick();
      armed = 1'b1;
      tick();
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_level", level, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_overflow", overflow, 0);
      rst_n = 1'b1;
      tick();
      check("rel_in_ready", in_ready, 1);

      // Single frame with latency
      out_ready = 1'b1;
      push(4'h3, 8'h2C);
      check("single_level", level, 1);
      check("single_not_yet", out_valid, 0);
      expect_frame("single", 8'hA3, 8'h2C, 8'h30);

      // Checksum wrap
      push(4'hB, 8'hFF);
      expect_frame("wrap", 8'hAB, 8'hFF, 8'h55);

      // Fill and overflow
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) push(4'(i), 8'(8'h10 * i + 1));
      check("fill_in_ready", in_ready, 0);
      check("fill_overflow", overflow, 1);
      check("fill_level", level, 4);
      out_ready = 1'b1;
      cnt = 0;
      for (int i = 0; i < 15; i++) begin
         if (out_valid) cnt++;
         tick();
      end
      check("drain_count", cnt, 15);
      check("drain_done", out_valid, 0);
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      check("clr_ovf", overflow, 0);

      // Backpressure
      out_ready = 1'b0;
      n0 = log_b.size();
      push(4'h5, 8'h11);
      for (int i = 0; i < 12; i++) begin
         out_ready = i[0];
         tick();
      end
      out_ready = 1'b1;
      tick();
      tick();
      check("bp_count", log_b.size(), n0 + 3);
      if (log_b.size() >= n0 + 3) begin
         check("bp_hdr", log_b[n0], 8'hA5);
         check("bp_dat", log_b[n0 + 1], 8'h11);
         check("bp_chk", log_b[n0 + 2], 8'h49);
      end

      // Simultaneous push/pop at full and at level 2
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) push(4'(i + 7), 8'(8'h33 + i));
      check("full_level", level, 4);
      out_ready = 1'b1;
      tick();
      tick();
      check("full_in_ready", in_ready, 0);
      push(4'hE, 8'hEE);
      check("full_pop_ovf", overflow, 1);
      check("full_pop_level", level, 3);
      for (int i = 0; i < 5; i++) tick();
      check("l2_level", level, 2);
      check("l2_in_ready", in_ready, 1);
      push(4'hD, 8'hDD);
      check("l2_push_pop_level", level, 2);
      for (int i = 0; i < 20; i++) tick();
      check("sim_drained_level", level, 0);
      check("sim_drained_valid", out_valid, 0);

      // Reset mid-frame
      out_ready = 1'b0;
      push(4'h1, 8'h42);
      push(4'h2, 8'h43);
      push(4'h3, 8'h44);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("mid_dat", out_data, 8'h42);
      check("mid_level", level, 2);
      rst_n = 1'b0;
      tick();
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_data", out_data, 0);
      check("mid_rst_level", level, 0);
      check("mid_rst_ovf", overflow, 0);
      check("mid_rst_fs", frame_start, 0);
      check("mid_rst_in_ready", in_ready, 0);
      rst_n = 1'b1;
      out_ready = 1'b1;
      n0 = log_b.size();
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (out_valid) cnt++;
      end
      check("post_rst_quiet", cnt, 0);
      check("post_rst_log", log_b.size(), n0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
